ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of a 5-stage MIPS pipeline, between the ID/EX and EX/MEM registers.
- Unpacks the 144-bit ID/EX bundle and performs one ALU operation on the two operands.
- Registers the result, together with pass-through fields, into the 71-bit EX/MEM bundle.

Parameters:
- DATA_W, 32, operand/result/data width
- REG_W, 5, destination register index width
- CTRL_W, 9, control field width
- IN_W, 144, id_ex_bundle width
- OUT_W, 71, ex_mem_bundle width

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- id_ex_bundle  input  144  packed ID/EX fields.
- ex_mem_bundle  output  71  registered EX/MEM fields.

Behaviour:
- Input field map:
  - [143:142] unused, ignored.
  - [141:133] ctrl[8:0].
  - [132:101] branch_target. Ignored; branch resolution is outside this block.
  - [100:69] alu_a.
  - [68:37] alu_b.
  - [36:5] read_data2.
  - [4:0] rd.
- ctrl decode:
  - ctrl[8:7] = WB control pair, forwarded unchanged.
  - ctrl[6:3] reserved, ignored.
  - ctrl[2:0] = ALU op.
- ALU op encoding (combinational result):
  - 000 AND = a & b
  - 001 OR = a | b
  - 010 ADD = a + b, modulo 2^32, carry discarded.
  - 110 SUB = a - b, modulo 2^32.
  - 111 SLT = 32'd1 if $signed(a) < $signed(b), else 0 (two's-complement compare).
  - 011, 100, 101 = 32'd0.
- Output field map:
  - [70:69] ctrl[8:7].
  - [68:37] alu_result.
  - [36:5] read_data2.
  - [4:0] rd.
- Timing: exactly one register stage. The bundle presented before rising edge N appears on ex_mem_bundle after edge N and holds until the next edge.
- Input changes between edges do not affect the output until the next rising edge.
- No handshake and no stall/flush input; every edge captures a new bundle.
- Reset: when reset==0 at a rising edge, ex_mem_bundle <= 71'b0, overriding capture.
  - Reset mid-stream discards the in-flight result.
  - The first valid output appears one edge after reset returns to 1.
- Before the first edge, ex_mem_bundle is unknown; the bench must apply reset first.
- No overflow flag and no exceptions on ADD/SUB overflow.

Decomposition:
- Package ex_pkg:
  - Bundle widths and field bit offsets for both bundles.
  - ALU op localparams: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT.
- Sub-module ex_alu: purely combinational; inputs a[31:0], b[31:0], op[2:0]; output result[31:0].
- ex_stage: field unpacking, ex_alu instance, and the output register with synchronous active-low reset.

Test Plan:
- Reset: hold reset=0 for 2 edges with nonzero input -> ex_mem_bundle == 0.
- ADD: reset=1, ctrl=9'b010000010, a=0x10, b=0x20, rd2=0, rd=1 -> after one edge: [70:69]=2'b01, result=0x00000030, rd2=0, rd=1.
- SUB and SLT:
  - ctrl=9'b010001110, a=0x30, b=0x10, rd=2 -> result=0x20.
  - ctrl=9'b010011111, a=5, b=0x10, rd=3 -> result=1.
  - a=0xFFFFFFFF (-1), b=1 -> result=1.
  - a=1, b=0xFFFFFFFF -> result=0.
- AND/OR:
  - ctrl=9'b010000000, a=0xFFFF, b=0xAAAA, rd=4 -> result=0xAAAA.
  - ctrl=9'b010000001, same operands, rd=5 -> result=0xFFFF.
  - rd2=0xDEADBEEF passes through unchanged in both cases.
- Wrap and undefined op:
  - ADD with a=0xFFFFFFFF, b=1 -> result=0.
  - op=3'b011 -> result=0.
  - Assert reset=0 while a valid op is in flight -> next output is all zeros, and nothing is retained after release.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: bundle widths, field offsets and ALU op codes for the execute stage
package ex_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CTRL_W = 9;
  localparam int IN_W   = 144;
  localparam int OUT_W  = 71;
  localparam int IN_CTRL_LO   = 133;
  localparam int IN_BT_LO     = 101;
  localparam int IN_A_LO      = 69;
  localparam int IN_B_LO      = 37;
  localparam int IN_RD2_LO    = 5;
  localparam int IN_RD_LO     = 0;
  localparam int OUT_WB_LO    = 69;
  localparam int OUT_RES_LO   = 37;
  localparam int OUT_RD2_LO   = 5;
  localparam int OUT_RD_LO    = 0;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX input bundle and EX/MEM output bundle of the execute stage
interface ex_stage_if;
  import ex_pkg::*;
  logic [IN_W-1:0]  id_ex_bundle;
  logic [OUT_W-1:0] ex_mem_bundle;
  modport master (output id_ex_bundle, input ex_mem_bundle);
  modport slave  (input id_ex_bundle, output ex_mem_bundle);
endinterface

// File: rtl/ex_alu.sv
// ex_alu: combinational ALU for AND/OR/ADD/SUB/SLT, zero for unused op codes
module ex_alu
  import ex_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result
);
  // select the operation; unused op codes yield zero
  always_comb begin
    result = op == ALU_AND ? a & b :
             op == ALU_OR  ? a | b :
             op == ALU_ADD ? a + b :
             op == ALU_SUB ? a - b :
             op == ALU_SLT ? {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)} :
             '0;
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: unpacks ID/EX, runs the ALU and registers the EX/MEM bundle
module ex_stage
  import ex_pkg::*;
(
  input logic clk,
  input logic reset,
  ex_stage_if.slave bus
);
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] alu_a, alu_b, read_data2, alu_result;
  logic [REG_W-1:0]  rd;
  logic              unused_bits;
  assign ctrl        = bus.id_ex_bundle[IN_CTRL_LO +: CTRL_W];
  assign alu_a       = bus.id_ex_bundle[IN_A_LO +: DATA_W];
  assign alu_b       = bus.id_ex_bundle[IN_B_LO +: DATA_W];
  assign read_data2  = bus.id_ex_bundle[IN_RD2_LO +: DATA_W];
  assign rd          = bus.id_ex_bundle[IN_RD_LO +: REG_W];
  assign unused_bits = ^{bus.id_ex_bundle[IN_W-1 -: 2], bus.id_ex_bundle[IN_BT_LO +: DATA_W], ctrl[6:3]};
  ex_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (ctrl[2:0]),
    .result (alu_result)
  );
  // capture a new bundle every edge; active-low reset clears it
  always_ff @(posedge clk) begin
    if (!reset) bus.ex_mem_bundle <= '0;
    else bus.ex_mem_bundle <= {ctrl[8:7], alu_result, read_data2, rd};
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for the execute stage
module tb_ex_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  ex_stage_if bus ();
  ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  function automatic logic [143:0] pack(input logic [8:0] c, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] r2, input logic [4:0] rd);
    return {2'b11, c, 32'hCAFEF00D, a, b, r2, rd};
  endfunction
  task automatic check(input string tag, input logic [70:0] exp);
    total++;
    assert (bus.ex_mem_bundle === exp)
    else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, bus.ex_mem_bundle, exp);
    end
  endtask
  task automatic step(input string tag, input logic [8:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r2, input logic [4:0] rd, input logic [70:0] exp);
    bus.id_ex_bundle = pack(c, a, b, r2, rd);
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask
  initial begin
    bus.id_ex_bundle = pack(9'b010000010, 32'h11, 32'h22, 32'h33, 5'd9);
    @(posedge clk);
    #1;
    check("reset1", 71'd0);
    @(posedge clk);
    #1;
    check("reset2", 71'd0);
    reset = 1'b1;
    step("add", 9'b010000010, 32'h10, 32'h20, 32'h0, 5'd1, {2'b01, 32'h30, 32'h0, 5'd1});
    bus.id_ex_bundle = pack(9'b110000110, 32'h99, 32'h1, 32'h77, 5'd31);
    #2;
    check("hold", {2'b01, 32'h30, 32'h0, 5'd1});
    step("sub", 9'b010001110, 32'h30, 32'h10, 32'h0, 5'd2, {2'b01, 32'h20, 32'h0, 5'd2});
    step("slt_pos", 9'b010011111, 32'h5, 32'h10, 32'h0, 5'd3, {2'b01, 32'h1, 32'h0, 5'd3});
    step("slt_neg_lt", 9'b010011111, 32'hFFFFFFFF, 32'h1, 32'h0, 5'd3, {2'b01, 32'h1, 32'h0, 5'd3});
    step("slt_neg_ge", 9'b010011111, 32'h1, 32'hFFFFFFFF, 32'h0, 5'd3, {2'b01, 32'h0, 32'h0, 5'd3});
    step("and", 9'b010000000, 32'hFFFF, 32'hAAAA, 32'hDEADBEEF, 5'd4, {2'b01, 32'hAAAA, 32'hDEADBEEF, 5'd4});
    step("or", 9'b010000001, 32'hFFFF, 32'hAAAA, 32'hDEADBEEF, 5'd5, {2'b01, 32'hFFFF, 32'hDEADBEEF, 5'd5});
    step("add_wrap", 9'b010000010, 32'hFFFFFFFF, 32'h1, 32'h0, 5'd6, {2'b01, 32'h0, 32'h0, 5'd6});
    step("sub_wrap", 9'b010000110, 32'h0, 32'h1, 32'h0, 5'd6, {2'b01, 32'hFFFFFFFF, 32'h0, 5'd6});
    step("op011", 9'b010000011, 32'h5, 32'h3, 32'h1234, 5'd7, {2'b01, 32'h0, 32'h1234, 5'd7});
    step("op100", 9'b010000100, 32'h5, 32'h3, 32'h1234, 5'd7, {2'b01, 32'h0, 32'h1234, 5'd7});
    step("op101", 9'b010000101, 32'h5, 32'h3, 32'h1234, 5'd7, {2'b01, 32'h0, 32'h1234, 5'd7});
    step("wb10_rsvd", 9'b101111010, 32'h1, 32'h2, 32'h55, 5'd8, {2'b10, 32'h3, 32'h55, 5'd8});
    reset = 1'b0;
    step("mid_reset", 9'b110000010, 32'h40, 32'h2, 32'h66, 5'd10, 71'd0);
    reset = 1'b1;
    step("post_reset", 9'b000000001, 32'hF0, 32'h0F, 32'h0, 5'd11, {2'b00, 32'hFF, 32'h0, 5'd11});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
